// File: rtl/parse_act_pkg.sv
// Shared types and default widths for the parse-action table.
package parse_act_pkg;

    localparam int unsigned PA_ADDR_BITS = 5;
    localparam int unsigned PA_DATA_BITS = 160;
    localparam int unsigned PA_TAG_BITS  = 8;
    localparam int unsigned PA_RSP_DEPTH = 4;
    localparam int unsigned PA_CRED_BITS = $clog2(PA_RSP_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RUN   = 2'd2
    } pa_state_e;

    typedef struct packed {
        logic [PA_DATA_BITS-1:0] data;
        logic                    hit;
        logic [PA_TAG_BITS-1:0]  tag;
    } pa_rsp_t;

    // Credit counter must hold the full range 0..depth inclusive.
    function automatic int unsigned cred_bits(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/parse_act_table_if.sv
// Config-write, lookup and response channels of the parse-action table.
interface parse_act_table_if
    import parse_act_pkg::*;
#(
    parameter int unsigned ADDR_BITS = PA_ADDR_BITS,
    parameter int unsigned DATA_BITS = PA_DATA_BITS,
    parameter int unsigned TAG_BITS  = PA_TAG_BITS
);
    logic                 wr_valid;
    logic                 wr_ready;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_data;
    logic                 wr_inval;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [TAG_BITS-1:0]  rd_tag;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATA_BITS-1:0] rsp_data;
    logic                 rsp_hit;
    logic [TAG_BITS-1:0]  rsp_tag;
    logic                 clear_req;
    logic                 busy;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_inval,
        output rd_valid, rd_addr, rd_tag, rsp_ready, clear_req,
        input  wr_ready, rd_ready, rsp_valid, rsp_data, rsp_hit, rsp_tag, busy
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_inval,
        input  rd_valid, rd_addr, rd_tag, rsp_ready, clear_req,
        output wr_ready, rd_ready, rsp_valid, rsp_data, rsp_hit, rsp_tag, busy
    );
endinterface

// File: rtl/parse_act_rsp_fifo.sv
// Response FIFO with a registered head: an entry pushed into an empty FIFO
// appears on the output the following cycle.
module parse_act_rsp_fifo
    import parse_act_pkg::*;
#(
    parameter int unsigned DEPTH = PA_RSP_DEPTH,
    parameter type         T     = pa_rsp_t
) (
    input  logic clk,
    input  logic aresetn,
    input  logic push,
    input  T     push_data,
    input  logic pop_ready,
    output logic out_valid,
    output T     out_data
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    T              mem_r [0:DEPTH-1];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    T              out_r;
    logic          out_v_r;
    logic          load_s;
    logic          from_mem_s;
    logic          store_s;

    // Head register reloads when empty or being consumed; an empty store lets a push go straight to the head.
    always_comb begin
        load_s     = (!out_v_r) || pop_ready;
        from_mem_s = load_s && (count_r != CW'(0));
        store_s    = push && !(load_s && (count_r == CW'(0)));
    end

    // Entry storage behind the head register.
    always_ff @(posedge clk) begin
        if (store_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and head register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            out_r    <= '0;
            out_v_r  <= 1'b0;
        end else begin
            if (store_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            case ({store_s, from_mem_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (load_s) begin
                if (from_mem_s) begin
                    out_r    <= mem_r[rd_ptr_r];
                    out_v_r  <= 1'b1;
                    rd_ptr_r <= rd_ptr_r + PW'(1);
                end else if (push) begin
                    out_r   <= push_data;
                    out_v_r <= 1'b1;
                end else begin
                    out_v_r <= 1'b0;
                end
            end
        end
    end

    assign out_valid = out_v_r;
    assign out_data  = out_r;
endmodule

// File: rtl/ram_blk.sv
// Simple dual-port RAM: one write port, one registered read port (read-old on collision).
module ram_blk #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 160
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_r [0:(2**AW)-1];

    // Storage write and registered read; collisions return the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end
endmodule

// File: rtl/parse_act_table.sv
// Parse-action table: write-first action store with valid bits, clear sweep,
// and a credit-controlled lookup/response path with tag passthrough.
module parse_act_table
    import parse_act_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = PA_ADDR_BITS,
    parameter int unsigned DATA_BITS     = PA_DATA_BITS,
    parameter int unsigned TAG_BITS      = PA_TAG_BITS,
    parameter int unsigned RSP_DEPTH     = PA_RSP_DEPTH,
    parameter int unsigned INIT_ON_RESET = 1
) (
    input  logic             clk,
    input  logic             aresetn,
    parse_act_table_if.slave bus
);
    localparam int unsigned          DEPTH      = 2 ** ADDR_BITS;
    localparam int unsigned          CRED_BITS  = cred_bits(RSP_DEPTH);
    localparam logic [CRED_BITS-1:0] CRED_MAX   = CRED_BITS'(RSP_DEPTH);
    localparam logic [ADDR_BITS-1:0] SWEEP_LAST = ADDR_BITS'(DEPTH - 1);

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 hit;
        logic [TAG_BITS-1:0]  tag;
    } rsp_t;

    pa_state_e            state_r, state_nxt_s;
    logic [ADDR_BITS-1:0] sweep_r;
    logic [CRED_BITS-1:0] cred_r, cred_nxt_s;
    logic                 wr_ready_r, rd_ready_r, busy_r;
    logic [DEPTH-1:0]     valid_r;
    logic                 s1_valid_r, s1_hit_r, s1_byp_r;
    logic [DATA_BITS-1:0] s1_byp_data_r;
    logic [TAG_BITS-1:0]  s1_tag_r;
    logic [DATA_BITS-1:0] ram_q_s, ram_wdata_s;
    logic [ADDR_BITS-1:0] ram_waddr_s;
    logic                 ram_we_s;
    logic                 wr_fire_s, rd_fire_s, rsp_fire_s, same_s;
    logic                 rsp_valid_s;
    rsp_t                 push_rsp_s, rsp_out_s;

    assign wr_fire_s   = bus.wr_valid && wr_ready_r;
    assign rd_fire_s   = bus.rd_valid && rd_ready_r;
    assign rsp_fire_s  = rsp_valid_s && bus.rsp_ready;
    assign same_s      = wr_fire_s && (bus.wr_addr == bus.rd_addr);

    // Next state: sweep to the end, wait for the RAM stage to empty, or accept a clear request.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (sweep_r == SWEEP_LAST) state_nxt_s = ST_RUN;
                else                       state_nxt_s = ST_INIT;
            end
            ST_DRAIN: begin
                if (!s1_valid_r) state_nxt_s = ST_INIT;
                else             state_nxt_s = ST_DRAIN;
            end
            ST_RUN: begin
                if (bus.clear_req) state_nxt_s = ST_DRAIN;
                else               state_nxt_s = ST_RUN;
            end
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // Credits track free response slots; accept and return in the same cycle cancel out.
    always_comb begin
        cred_nxt_s = cred_r;
        case ({rd_fire_s, rsp_fire_s})
            2'b10:   cred_nxt_s = cred_r - CRED_BITS'(1);
            2'b01:   cred_nxt_s = cred_r + CRED_BITS'(1);
            default: cred_nxt_s = cred_r;
        endcase
    end

    // RAM write port is owned by the sweep while clearing, otherwise by accepted data writes.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = bus.wr_addr;
        ram_wdata_s = bus.wr_data;
        if (state_r == ST_INIT) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = sweep_r;
            ram_wdata_s = '0;
        end else begin
            ram_we_s = wr_fire_s && !bus.wr_inval;
        end
    end

    // FSM state, sweep counter, credits and the registered ready/busy outputs.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_r    <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            sweep_r    <= '0;
            cred_r     <= CRED_MAX;
            wr_ready_r <= 1'b0;
            rd_ready_r <= 1'b0;
            busy_r     <= (INIT_ON_RESET != 0);
        end else begin
            state_r    <= state_nxt_s;
            sweep_r    <= (state_r == ST_INIT) ? (sweep_r + ADDR_BITS'(1)) : '0;
            cred_r     <= cred_nxt_s;
            wr_ready_r <= (state_nxt_s == ST_RUN);
            rd_ready_r <= (state_nxt_s == ST_RUN) && (cred_nxt_s != CRED_BITS'(0));
            busy_r     <= (state_nxt_s == ST_INIT);
        end
    end

    // Per-entry valid bits: cleared by the sweep, set or cleared by writes.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            valid_r <= '0;
        end else if (state_r == ST_INIT) begin
            valid_r[sweep_r] <= 1'b0;
        end else if (wr_fire_s) begin
            valid_r[bus.wr_addr] <= !bus.wr_inval;
        end
    end

    // Lookup stage alongside the RAM read: captures tag, hit and a same-cycle write bypass.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid_r    <= 1'b0;
            s1_hit_r      <= 1'b0;
            s1_byp_r      <= 1'b0;
            s1_byp_data_r <= '0;
            s1_tag_r      <= '0;
        end else begin
            s1_valid_r <= rd_fire_s;
            if (rd_fire_s) begin
                s1_tag_r      <= bus.rd_tag;
                s1_hit_r      <= same_s ? !bus.wr_inval : valid_r[bus.rd_addr];
                s1_byp_r      <= same_s && !bus.wr_inval;
                s1_byp_data_r <= bus.wr_data;
            end
        end
    end

    // Assemble the response; a miss always carries zero data.
    always_comb begin
        push_rsp_s     = '0;
        push_rsp_s.tag = s1_tag_r;
        push_rsp_s.hit = s1_hit_r;
        if (s1_hit_r) begin
            push_rsp_s.data = s1_byp_r ? s1_byp_data_r : ram_q_s;
        end else begin
            push_rsp_s.data = '0;
        end
    end

    ram_blk #(.AW(ADDR_BITS), .DW(DATA_BITS)) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .re    (rd_fire_s),
        .raddr (bus.rd_addr),
        .rdata (ram_q_s)
    );

    parse_act_rsp_fifo #(.DEPTH(RSP_DEPTH), .T(rsp_t)) u_rsp_fifo (
        .clk       (clk),
        .aresetn   (aresetn),
        .push      (s1_valid_r),
        .push_data (push_rsp_s),
        .pop_ready (bus.rsp_ready),
        .out_valid (rsp_valid_s),
        .out_data  (rsp_out_s)
    );

    assign bus.wr_ready  = wr_ready_r;
    assign bus.rd_ready  = rd_ready_r;
    assign bus.busy      = busy_r;
    assign bus.rsp_valid = rsp_valid_s;
    assign bus.rsp_data  = rsp_out_s.data;
    assign bus.rsp_hit   = rsp_out_s.hit;
    assign bus.rsp_tag   = rsp_out_s.tag;
endmodule

// File: tb/tb_parse_act_table.sv
// Directed bench for parse_act_table with default parameters (DEPTH=32, RSP_DEPTH=4).
module tb_parse_act_table;
    logic clk = 1'b0;
    logic aresetn;
    int   vecs = 0;
    int   errs = 0;

    localparam logic [159:0] D_A5   = {20{8'hA5}};
    localparam logic [159:0] D_77   = {20{8'h77}};
    localparam logic [159:0] D_1234 = 160'h1234;
    localparam logic [159:0] D_BEEF = 160'hBEEF;

    always #5 clk = ~clk;

    parse_act_table_if bus ();

    parse_act_table dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] pack_rsp(input logic v, input logic h, input logic [7:0] t,
                                              input logic [159:0] d);
        return {22'd0, v, h, t, d};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_rsp(input string tag, input logic h, input logic [159:0] d, input logic [7:0] t);
        check(tag, pack_rsp(bus.rsp_valid, bus.rsp_hit, bus.rsp_tag, bus.rsp_data),
              pack_rsp(1'b1, h, t, d));
    endtask

    task automatic wait_rsp();
        int t;
        t = 0;
        while (!bus.rsp_valid && t < 20) begin
            tick();
            t++;
        end
    endtask

    task automatic burst(output int acc);
        bus.rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.rd_valid = 1'b1;
            bus.rd_addr  = (i % 2 == 0) ? 5'd3 : 5'd5;
            bus.rd_tag   = 8'(8'h40 + i);
            if (bus.rd_ready) acc++;
            tick();
        end
        bus.rd_valid = 1'b0;
    endtask

    task automatic drain(input string pfx);
        bus.rsp_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wait_rsp();
            check_rsp($sformatf("%s%0d", pfx, j), 1'b1, (j % 2 == 0) ? D_A5 : D_BEEF, 8'(8'h40 + j));
            tick();
        end
    endtask

    task automatic count_busy(output int n);
        int t;
        t = 0;
        n = 0;
        while (!bus.busy && t < 10) begin
            tick();
            t++;
        end
        while (bus.busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int acc;
        int stale;
        aresetn       = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = 5'd0;
        bus.wr_data   = 160'd0;
        bus.wr_inval  = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rd_addr   = 5'd0;
        bus.rd_tag    = 8'd0;
        bus.rsp_ready = 1'b1;
        bus.clear_req = 1'b0;
        repeat (3) tick();
        check("reset_rsp", pack_rsp(bus.rsp_valid, bus.rsp_hit, bus.rsp_tag, bus.rsp_data),
              pack_rsp(1'b0, 1'b0, 8'd0, 160'd0));
        check("reset_ctl", 192'({bus.rd_ready, bus.wr_ready, bus.busy}), 192'(3'b001));

        // Power-up sweep
        aresetn = 1'b1;
        #1;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            tick();
        end
        check("sweep_cycles", 192'(n), 192'(32));
        check("ready_after_sweep", 192'({bus.rd_ready, bus.wr_ready, bus.busy}), 192'(3'b110));

        // Lookup of an empty entry, exact two-cycle latency
        bus.rd_valid = 1'b1; bus.rd_addr = 5'd7; bus.rd_tag = 8'h07;
        tick();
        bus.rd_valid = 1'b0;
        check("lat_n1_idle", 192'(bus.rsp_valid), 192'(1'b0));
        tick();
        check_rsp("miss7", 1'b0, 160'd0, 8'h07);
        tick();

        // Write then read next cycle
        bus.wr_valid = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = D_A5; bus.wr_inval = 1'b0;
        tick();
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b1; bus.rd_addr = 5'd3; bus.rd_tag = 8'h11;
        tick();
        bus.rd_valid = 1'b0;
        check("lat_w3_idle", 192'(bus.rsp_valid), 192'(1'b0));
        tick();
        check_rsp("hit3", 1'b1, D_A5, 8'h11);
        tick();

        // Same-cycle write/read bypass; a following write must not leak in
        bus.wr_valid = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = D_1234;
        bus.rd_valid = 1'b1; bus.rd_addr = 5'd5; bus.rd_tag = 8'h22;
        tick();
        bus.rd_valid = 1'b0; bus.wr_data = D_BEEF;
        tick();
        bus.wr_valid = 1'b0;
        check_rsp("bypass5", 1'b1, D_1234, 8'h22);
        tick();
        bus.rd_valid = 1'b1; bus.rd_addr = 5'd5; bus.rd_tag = 8'h23;
        tick();
        bus.rd_valid = 1'b0;
        tick();
        check_rsp("later5", 1'b1, D_BEEF, 8'h23);
        tick();

        // Backpressure: credits limit acceptance, output holds, order preserved
        burst(acc);
        check("burst1_accepted", 192'(acc), 192'(4));
        check("burst1_rd_ready", 192'(bus.rd_ready), 192'(1'b0));
        check_rsp("hold_a", 1'b1, D_A5, 8'h40);
        tick();
        tick();
        check_rsp("hold_b", 1'b1, D_A5, 8'h40);
        drain("order");
        check("credits_back", 192'(bus.rd_ready), 192'(1'b1));
        burst(acc);
        check("burst2_accepted", 192'(acc), 192'(4));
        drain("order2_");

        // Invalidate then rewrite
        bus.wr_valid = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = D_BEEF; bus.wr_inval = 1'b1;
        tick();
        bus.wr_valid = 1'b0; bus.wr_inval = 1'b0;
        bus.rd_valid = 1'b1; bus.rd_addr = 5'd3; bus.rd_tag = 8'h31;
        tick();
        bus.rd_valid = 1'b0;
        tick();
        check_rsp("inval3", 1'b0, 160'd0, 8'h31);
        tick();
        bus.wr_valid = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = D_77;
        tick();
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b1; bus.rd_addr = 5'd3; bus.rd_tag = 8'h32;
        tick();
        bus.rd_valid = 1'b0;
        tick();
        check_rsp("rewrite3", 1'b1, D_77, 8'h32);
        tick();

        // Clear request with two reads in flight
        bus.rd_valid = 1'b1; bus.rd_addr = 5'd3; bus.rd_tag = 8'h61;
        tick();
        bus.rd_addr = 5'd5; bus.rd_tag = 8'h62; bus.clear_req = 1'b1;
        tick();
        bus.rd_valid = 1'b0; bus.clear_req = 1'b0;
        check("drain_ready", 192'({bus.rd_ready, bus.wr_ready}), 192'(2'b00));
        check_rsp("clr_a", 1'b1, D_77, 8'h61);
        tick();
        check_rsp("clr_b", 1'b1, D_BEEF, 8'h62);
        tick();
        count_busy(n);
        check("clear_sweep_cycles", 192'(n), 192'(32));
        check("ready_after_clear", 192'({bus.rd_ready, bus.wr_ready, bus.busy}), 192'(3'b110));
        for (int c = 0; c < 34; c++) begin
            if (c < 32) begin
                bus.rd_valid = 1'b1; bus.rd_addr = 5'(c); bus.rd_tag = 8'(c);
            end else begin
                bus.rd_valid = 1'b0;
            end
            if (c >= 2) check_rsp($sformatf("cleared%0d", c - 2), 1'b0, 160'd0, 8'(c - 2));
            tick();
        end
        bus.rd_valid = 1'b0;

        // Reset mid-stream discards buffered responses
        bus.rsp_ready = 1'b0;
        bus.rd_valid = 1'b1; bus.rd_addr = 5'd3; bus.rd_tag = 8'h71;
        tick();
        bus.rd_addr = 5'd5; bus.rd_tag = 8'h72;
        tick();
        bus.rd_valid = 1'b0;
        tick();
        check("pre_reset_valid", 192'(bus.rsp_valid), 192'(1'b1));
        aresetn = 1'b0;
        #1;
        check("reset_async_valid", 192'(bus.rsp_valid), 192'(1'b0));
        tick();
        aresetn = 1'b1;
        bus.rsp_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 45; c++) begin
            if (bus.rsp_valid) stale++;
            tick();
        end
        check("no_stale_rsp", 192'(stale), 192'(0));
        check("ready_after_reset", 192'({bus.rd_ready, bus.wr_ready, bus.busy}), 192'(3'b110));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/parse_act_table.md
# parse_act_table

Parametrised parse-action table for the menshen parser: a single-clock, write-first action store with per-entry valid bits, a hardware clear sequencer, and a credit-controlled read request/response interface with backpressure and tag passthrough. It sits between the control-path config writer and the parser's action lookup. It replaces a bare dual-port RAM wrapper so the parser can stall on `rsp_ready` without losing lookups.

## Interface
- `ADDR_BITS`, 5, entry address width; DEPTH = 2**ADDR_BITS
- `DATA_BITS`, 160, action word width
- `TAG_BITS`, 8, opaque request tag width
- `RSP_DEPTH`, 4, response buffer entries (power of two, ≥2)
- `INIT_ON_RESET`, 1, 1 = run clear sweep after reset release; 0 = enter RUN directly
- `clk` in 1 — single clock, all logic rising-edge
- `aresetn` in 1 — asynchronous, active-low reset
- `wr_valid` in 1 — config write request
- `wr_ready` out 1 — write accepted when `wr_valid && wr_ready`
- `wr_addr` in ADDR_BITS — write address
- `wr_data` in DATA_BITS — action word
- `wr_inval` in 1 — 1 = clear entry valid bit only, data unchanged
- `rd_valid` in 1 — lookup request
- `rd_ready` out 1 — lookup accepted when `rd_valid && rd_ready`
- `rd_addr` in ADDR_BITS — lookup address
- `rd_tag` in TAG_BITS — returned unchanged with response
- `rsp_valid` out 1 — response available
- `rsp_ready` in 1 — response consumed when `rsp_valid && rsp_ready`
- `rsp_data` out DATA_BITS — action word (zero if entry invalid)
- `rsp_hit` out 1 — entry valid bit at lookup time
- `rsp_tag` out TAG_BITS — tag of request
- `clear_req` in 1 — pulse: start clear sweep
- `busy` out 1 — clear sweep in progress

## Operation
- FSM states: INIT, DRAIN, RUN.
- INIT: counter sweeps addresses 0..DEPTH-1, one per cycle, writing zero data and clearing valid bit. After DEPTH-1 is written, the next state is RUN. `busy`=1; `wr_ready`=`rd_ready`=0.
- RUN: `wr_ready`=1. `rd_ready`=1 iff credits>0.
- `clear_req` in RUN: go to DRAIN. `rd_ready`=0 and `wr_ready`=0 from the next cycle. Once in-flight reads complete (RAM pipe empty), go to INIT. Responses already buffered remain deliverable during INIT.
- `clear_req` during INIT or DRAIN: ignored.
- Write: non-inval sets valid[addr]=1 and writes data. Inval clears valid[addr] and does not write the RAM.
- Credits: start at RSP_DEPTH.
  - Decrement on read accept.
  - Increment on response handshake.
  - Simultaneous accept and handshake: unchanged.
  - Credits never exceed RSP_DEPTH and never underflow.
- Read semantics are write-first. A response reflects all writes accepted in earlier cycles plus a write to the same address accepted in the same cycle as the read. Later writes do not affect it. The same-cycle case is resolved by address compare plus bypass register, not by RAM collision behaviour.
- `rsp_hit`=0: `rsp_data` forced to zero.
- Responses are returned in request order.

## Timing
- Reset values: `rsp_valid`=0, `rsp_data`=0, `rsp_hit`=0, `rsp_tag`=0, `rd_ready`=0, `wr_ready`=0. Credits = RSP_DEPTH. Valid bits all 0.
- Reset state: INIT with `busy`=1 when INIT_ON_RESET=1; otherwise RUN with `busy`=0.
- Clear sweep takes exactly DEPTH cycles. `rd_ready`/`wr_ready` rise on the cycle after the last sweep write.
- Read latency: a lookup accepted at cycle N with an empty buffer and `rsp_ready`=1 gives `rsp_valid`=1 at N+2 (registered RAM read, then response register).
- Sustained throughput: 1 lookup/cycle while `rsp_ready`=1.
- `rsp_*` are held stable while `rsp_valid && !rsp_ready`.
- Asserting `aresetn` low mid-operation discards in-flight and buffered responses immediately. No response is emitted after reset release for a request accepted before reset.

## Structure
- Package `parse_act_pkg`: state enum (INIT/DRAIN/RUN), response struct {data, hit, tag}, credit-width localparam $clog2(RSP_DEPTH+1).
- Storage: existing `ram_blk` for data; flop vector for valid bits.
- Sub-module `parse_act_rsp_fifo`: RSP_DEPTH-entry synchronous FIFO of the response struct with a registered output. Top level holds FSM, credits, bypass, and valid bits.

## Test plan
- Reset with INIT_ON_RESET=1, DEPTH=32: `busy`=1 for 32 cycles, then `rd_ready`=`wr_ready`=1. A lookup of addr 7 returns hit=0, data=0.
- Write addr 3 = 0xA5.., then read addr 3 tag 0x11 next cycle: at N+2, rsp_valid=1, hit=1, data=0xA5.., tag=0x11.
- Same-cycle write addr 5 = 0x1234 and read addr 5: response data=0x1234, hit=1. A write to addr 5 in cycle N+1 does not alter that response.
- Hold `rsp_ready`=0 and issue 6 back-to-back reads with RSP_DEPTH=4: exactly 4 accepted, `rd_ready`=0 after. Release `rsp_ready`: responses arrive in order with correct tags and credits return to 4.
- `wr_inval` on addr 3, then read: hit=0, data=0. Rewrite addr 3: hit=1 with the new data.
- `clear_req` with 2 reads in flight: both responses delivered, then `busy`=1 for 32 cycles, then all entries read hit=0. Drop `aresetn` mid-stream: `rsp_valid`=0 immediately and no stale response after release.
